// File: rtl/inst_fetch_queue.sv
// Dual-write / dual-read instruction queue between I-cache output and decode.
// Presents the two oldest entries; pops clamp to occupancy, pushes drop when full.
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [31:0]      in_inst1,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst2,
    input  logic [31:0]      in_pc2,
    output logic             full_o,
    input  logic [1:0]       pop_num,
    output logic             out_valid1,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_pc1,
    output logic             out_valid2,
    output logic [31:0]      out_inst2,
    output logic [31:0]      out_pc2,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 1);

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]       push_n;
    logic [1:0]       pop_req;
    logic [1:0]       pop_eff;
    logic [PTR_W:0]   pop_req_w;
    logic [PTR_W-1:0] tail1;
    logic [PTR_W-1:0] head1;

    assign full_o = count_q >= FULL_TH;
    assign tail1  = tail_q + 1'b1;
    assign head1  = head_q + 1'b1;

    always_comb begin
        push_n = 2'd0;
        if (!full_o && in_valid1)
            push_n = in_valid2 ? 2'd2 : 2'd1;
    end

    // Pop request of 3 means "both"; never pop more than is stored.
    assign pop_req   = (pop_num == 2'd3) ? 2'd2 : pop_num;
    assign pop_req_w = {{(PTR_W-1){1'b0}}, pop_req};
    assign pop_eff   = (count_q < pop_req_w) ? count_q[1:0] : pop_req;

    always_comb begin
        head_d  = head_q + {{(PTR_W-2){1'b0}}, pop_eff};
        tail_d  = tail_q + {{(PTR_W-2){1'b0}}, push_n};
        count_d = count_q
                + {{(PTR_W-1){1'b0}}, push_n}
                - {{(PTR_W-1){1'b0}}, pop_eff};
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            inst_q[tail_q] <= in_inst1;
            pc_q[tail_q]   <= in_pc1;
        end
        if (push_n == 2'd2) begin
            inst_q[tail1] <= in_inst2;
            pc_q[tail1]   <= in_pc2;
        end
    end

    assign count_o    = count_q;
    assign out_valid1 = count_q >= (PTR_W+1)'(1);
    assign out_valid2 = count_q >= (PTR_W+1)'(2);

    assign out_inst1 = out_valid1 ? inst_q[head_q] : 32'd0;
    assign out_pc1   = out_valid1 ? pc_q[head_q]   : 32'd0;
    assign out_inst2 = out_valid2 ? inst_q[head1]  : 32'd0;
    assign out_pc2   = out_valid2 ? pc_q[head1]    : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, push/pop, fill, clamp,
// wrap-around streaming and flush.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid1, in_valid2;
    logic [31:0] in_inst1, in_pc1, in_inst2, in_pc2;
    logic        full_o;
    logic [1:0]  pop_num;
    logic        out_valid1, out_valid2;
    logic [31:0] out_inst1, out_pc1, out_inst2, out_pc2;
    logic [4:0]  count_o;

    int total = 0;
    int bad   = 0;

    inst_fetch_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid1(in_valid1), .in_valid2(in_valid2),
        .in_inst1(in_inst1), .in_pc1(in_pc1),
        .in_inst2(in_inst2), .in_pc2(in_pc2),
        .full_o(full_o), .pop_num(pop_num),
        .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
        .out_valid2(out_valid2), .out_inst2(out_inst2), .out_pc2(out_pc2),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic v2,
                         input logic [31:0] p1, input logic [31:0] p2,
                         input logic [1:0] pop, input logic fl);
        in_valid1 = v1;
        in_valid2 = v2;
        in_pc1    = p1;
        in_pc2    = p2;
        in_inst1  = inst_of(p1);
        in_inst2  = inst_of(p2);
        pop_num   = pop;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom,
                  2'($urandom), 1'($urandom));
            step();
        end
        idle();
        #1;
        total++;
        if (count_o !== 5'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", count_o);
        end
        total++;
        if ({out_valid1, out_valid2, full_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000",
                     {out_valid1, out_valid2, full_o});
        end
        total++;
        if ({out_inst1, out_pc1, out_inst2, out_pc2} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h exp=0",
                     out_inst1, out_pc1, out_inst2, out_pc2);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_dual_push();
        drive(1'b1, 1'b1, 32'h1000, 32'h1004, 2'd0, 1'b0);
        in_inst1 = 32'hAAAA0001;
        in_inst2 = 32'hAAAA0002;
        step();
        idle();
        total++;
        if ({out_valid1, out_valid2} !== 2'b11 || count_o !== 5'd2) begin
            bad++;
            $display("FAIL dual_valid got=%b cnt=%0d exp=11 cnt=2",
                     {out_valid1, out_valid2}, count_o);
        end
        total++;
        if (out_pc1 !== 32'h1000 || out_pc2 !== 32'h1004) begin
            bad++;
            $display("FAIL dual_pc got=%h %h exp=1000 1004", out_pc1, out_pc2);
        end
        total++;
        if (out_inst1 !== 32'hAAAA0001 || out_inst2 !== 32'hAAAA0002) begin
            bad++;
            $display("FAIL dual_inst got=%h %h exp=aaaa0001 aaaa0002",
                     out_inst1, out_inst2);
        end
        pop_num = 2'd1;
        step();
        idle();
        total++;
        if (out_pc1 !== 32'h1004 || out_valid2 !== 1'b0 || count_o !== 5'd1) begin
            bad++;
            $display("FAIL pop1 got pc=%h v2=%b cnt=%0d exp pc=1004 v2=0 cnt=1",
                     out_pc1, out_valid2, count_o);
        end
        total++;
        if (out_pc2 !== 32'd0 || out_inst2 !== 32'd0) begin
            bad++;
            $display("FAIL pop1_zero got=%h %h exp=0", out_pc2, out_inst2);
        end
        pop_num = 2'd1;
        step();
        idle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 8*i, 32'h104 + 8*i, 2'd0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 32'h138, 32'h0, 2'd0, 1'b0);
        step();
        idle();
        total++;
        if (count_o !== 5'd15 || full_o !== 1'b1) begin
            bad++;
            $display("FAIL fill got cnt=%0d full=%b exp cnt=15 full=1",
                     count_o, full_o);
        end
        drive(1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004, 2'd0, 1'b0);
        step();
        idle();
        total++;
        if (count_o !== 5'd15 || out_pc1 !== 32'h100 || out_pc2 !== 32'h104) begin
            bad++;
            $display("FAIL full_drop got cnt=%0d pc=%h %h exp cnt=15 pc=100 104",
                     count_o, out_pc1, out_pc2);
        end
        pop_num = 2'd2;
        step();
        idle();
        total++;
        if (count_o !== 5'd13 || full_o !== 1'b0 || out_pc1 !== 32'h108) begin
            bad++;
            $display("FAIL unfill got cnt=%0d full=%b pc=%h exp cnt=13 full=0 pc=108",
                     count_o, full_o, out_pc1);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (out_pc1 !== 32'h108 + 8*i || out_inst1 !== inst_of(32'h108 + 8*i)) begin
                bad++;
                $display("FAIL drain_%0d got pc=%h inst=%h exp pc=%h", i,
                         out_pc1, out_inst1, 32'h108 + 8*i);
            end
            pop_num = 2'd2;
            step();
        end
        idle();
        total++;
        if (count_o !== 5'd0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL drain_end got cnt=%0d v1=%b exp cnt=0 v1=0",
                     count_o, out_valid1);
        end
    endtask

    task automatic test_concurrent();
        drive(1'b1, 1'b1, 32'h400, 32'h404, 2'd0, 1'b0); step();
        drive(1'b1, 1'b1, 32'h408, 32'h40C, 2'd0, 1'b0); step();
        drive(1'b1, 1'b0, 32'h410, 32'h0, 2'd0, 1'b0); step();
        idle();
        total++;
        if (count_o !== 5'd5 || out_pc1 !== 32'h400) begin
            bad++;
            $display("FAIL conc_setup got cnt=%0d pc=%h exp cnt=5 pc=400",
                     count_o, out_pc1);
        end
        drive(1'b1, 1'b1, 32'h414, 32'h418, 2'd2, 1'b0);
        step();
        idle();
        total++;
        if (count_o !== 5'd5 || out_pc1 !== 32'h408 || out_pc2 !== 32'h40C) begin
            bad++;
            $display("FAIL conc_pushpop got cnt=%0d pc=%h %h exp cnt=5 pc=408 40c",
                     count_o, out_pc1, out_pc2);
        end
        pop_num = 2'd2; step();
        pop_num = 2'd2; step();
        idle();
        total++;
        if (count_o !== 5'd1 || out_pc1 !== 32'h418 || out_inst1 !== inst_of(32'h418)) begin
            bad++;
            $display("FAIL conc_order got cnt=%0d pc=%h exp cnt=1 pc=418",
                     count_o, out_pc1);
        end
        pop_num = 2'd3;
        step();
        idle();
        total++;
        if (count_o !== 5'd0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL pop3_clamp got cnt=%0d v1=%b exp cnt=0 v1=0",
                     count_o, out_valid1);
        end
        drive(1'b0, 1'b1, 32'h0, 32'h500, 2'd0, 1'b0);
        step();
        idle();
        total++;
        if (count_o !== 5'd0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL v2_only got cnt=%0d v1=%b exp cnt=0 v1=0",
                     count_o, out_valid1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] next_pc = 32'h2000;
        logic [31:0] exp_pc  = 32'h2000;
        int mcount = 0;
        int cycles = 0;
        int pn, pr, pe;
        while (exp_pc != 32'h20A0 && cycles < 500) begin
            total++;
            if (count_o !== 5'(mcount)) begin
                bad++;
                $display("FAIL wrap_cnt cyc=%0d got=%0d exp=%0d",
                         cycles, count_o, mcount);
            end
            if (mcount >= 1) begin
                total++;
                if (out_pc1 !== exp_pc || out_inst1 !== inst_of(exp_pc)) begin
                    bad++;
                    $display("FAIL wrap_pc1 cyc=%0d got=%h exp=%h",
                             cycles, out_pc1, exp_pc);
                end
            end
            if (mcount >= 2) begin
                total++;
                if (out_pc2 !== exp_pc + 4) begin
                    bad++;
                    $display("FAIL wrap_pc2 cyc=%0d got=%h exp=%h",
                             cycles, out_pc2, exp_pc + 4);
                end
            end
            pn = int'($urandom_range(0, 2));
            if (pn > int'((32'h20A0 - next_pc) >> 2))
                pn = int'((32'h20A0 - next_pc) >> 2);
            pr = int'($urandom_range(0, 3));
            drive(pn >= 1, pn == 2, next_pc, next_pc + 4, 2'(pr), 1'b0);
            if (pr == 3) pr = 2;
            pe = (pr < mcount) ? pr : mcount;
            if (mcount >= 15) pn = 0;
            exp_pc  = exp_pc + 32'(4 * pe);
            next_pc = next_pc + 32'(4 * pn);
            mcount  = mcount + pn - pe;
            step();
            cycles++;
        end
        idle();
        total++;
        if (exp_pc != 32'h20A0 || count_o !== 5'd0) begin
            bad++;
            $display("FAIL wrap_end got last=%h cnt=%0d exp last=20a0 cnt=0",
                     exp_pc, count_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h600 + 8*i, 32'h604 + 8*i, 2'd0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 32'h620, 32'h0, 2'd0, 1'b0);
        step();
        idle();
        total++;
        if (count_o !== 5'd9) begin
            bad++; $display("FAIL flush_setup got=%0d exp=9", count_o);
        end
        drive(1'b1, 1'b1, 32'h700, 32'h704, 2'd2, 1'b1);
        step();
        idle();
        total++;
        if (count_o !== 5'd0 || out_valid1 !== 1'b0 || out_pc1 !== 32'd0) begin
            bad++;
            $display("FAIL flush got cnt=%0d v1=%b pc=%h exp cnt=0 v1=0 pc=0",
                     count_o, out_valid1, out_pc1);
        end
        drive(1'b1, 1'b0, 32'h3000, 32'h0, 2'd0, 1'b0);
        step();
        idle();
        total++;
        if (out_valid1 !== 1'b1 || out_pc1 !== 32'h3000 ||
            out_inst1 !== inst_of(32'h3000) || count_o !== 5'd1) begin
            bad++;
            $display("FAIL post_flush got v1=%b pc=%h cnt=%0d exp v1=1 pc=3000 cnt=1",
                     out_valid1, out_pc1, count_o);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_dual_push();
        test_fill();
        test_concurrent();
        test_wrap();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-write, dual-read instruction FIFO between the instruction cache output stage and the dual-issue decode stage.
- Accepts 0–2 instructions per cycle from the cache (data_ok1/data_ok2, rdata1/rdata2, raddr1/raddr2) and presents the two oldest entries to decode.
- Decode pops 0–2 entries per cycle.
- full_o back-pressures the fetch/PC stage; flush discards all buffered instructions on redirect.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
PTR_W, 4, pointer width, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
flush  input  1  discard all entries (branch/exception redirect)
in_valid1  input  1  slot-1 instruction valid (from cache data_ok1)
in_valid2  input  1  slot-2 instruction valid (from cache data_ok2)
in_inst1  input  32  slot-1 instruction word
in_pc1  input  32  slot-1 instruction address
in_inst2  input  32  slot-2 instruction word
in_pc2  input  32  slot-2 instruction address
full_o  output  1  fewer than 2 free entries; upstream must not push
pop_num  input  2  entries consumed by decode this cycle (0/1/2; 3 treated as 2)
out_valid1  output  1  head entry valid
out_inst1  output  32  head instruction
out_pc1  output  32  head address
out_valid2  output  1  head+1 entry valid
out_inst2  output  32  head+1 instruction
out_pc2  output  32  head+1 address
count_o  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- State
  - Storage: DEPTH x {inst[31:0], pc[31:0]}.
  - Registered head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset and flush
  - rst=0 at a clock edge: head=0, tail=0, count=0. Storage contents are don't-care.
  - Outputs after reset: full_o=0, out_valid1/2=0, out_inst/out_pc=0, count_o=0.
  - flush=1 (rst=1): same effect as reset on head, tail and count. Pushes and pops in that cycle are ignored. Reset has priority over flush.
- Push
  - push_en = !full_o (full_o uses registered count only; a same-cycle pop does not relieve it).
  - push_n = 0 if !push_en or !in_valid1; else 1 + in_valid2.
  - in_valid2 without in_valid1 is ignored (push_n=0).
  - Slot 1 is written at tail, slot 2 at tail+1 (mod DEPTH); tail += push_n.
  - Any push while full_o=1 is dropped entirely; upstream holds its request via the stall.
- Pop
  - pop_eff = min(pop_num==3 ? 2 : pop_num, count); head += pop_eff.
  - Popping beyond occupancy is clamped and never underflows.
- Count
  - count_next = count + push_n - pop_eff.
  - Simultaneous push and pop in the same cycle is legal.
- Outputs
  - All outputs are combinational from registered state.
  - full_o = (DEPTH - count) < 2.
  - out_valid1 = count >= 1; out_valid2 = count >= 2.
  - out_inst1/out_pc1 = storage[head]; out_inst2/out_pc2 = storage[head+1 mod DEPTH].
  - Each data/pc pair is forced to 0 when its valid is low.
- Latency and ordering
  - A pushed instruction appears on the outputs the cycle after the push. There is no write-to-read bypass.
  - Program order is strictly preserved across the pointer wrap; slot 1 is always older than slot 2.
- No assertion or error outputs; illegal inputs are handled by the clamp/drop rules above.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with random inputs -> count_o=0, out_valid1/2=0, out_inst/out_pc=0, full_o=0.
2. Dual push: in_valid1/2=1, pc 0x1000/0x1004, inst 0xAAAA0001/0xAAAA0002 -> next cycle out_valid1=out_valid2=1, out_pc1=0x1000, out_pc2=0x1004, count_o=2. Then pop_num=1 -> out_pc1=0x1004, out_valid2=0.
3. Fill: 7 dual pushes + 1 single push -> count_o=15, full_o=1. A dual push attempted now -> count stays 15 and data unchanged. pop_num=2 -> count 13, full_o=0.
4. Concurrent and clamped ops:
   - count=5, dual push with pop_num=2 -> count stays 5, head pc advances by 8, ordering intact.
   - count=1, pop_num=3 -> count 0.
   - in_valid2=1 with in_valid1=0 -> no write.
5. Wrap-around: stream 40 sequential pcs from 0x2000 (step 4) with random push_n and random pop_num -> decode observes 0x2000..0x209C in order, with no loss or duplication.
6. Flush: count=9, flush=1 with a simultaneous dual push and pop_num=2 -> next cycle count_o=0, out_valid1=0. A subsequent push of pc 0x3000 appears at out_pc1.
